// File: rtl/sobel_window_gen.sv
// ---------------------------------------------------------------------------
// sobel_window_gen
//   Feeds the 3x3 Sobel kernel stage. A raster-order pixel stream is buffered
//   in two line memories plus a small column history. For every interior
//   pixel the eight neighbours are presented in kernel order with a strobe.
//   Border centres (row/col 0 or last) never produce an output.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous active-high reset
//   in_valid   : in_pixel accepted this cycle (no backpressure)
//   in_pixel   : raster pixel, DW bits unsigned
//   out_valid  : win0..win7, out_x, out_y valid this cycle
//   win0..win7 : neighbours 0=TL 1=T 2=TR 3=L 4=R 5=BL 6=B 7=BR
//   out_x      : column of the centre pixel
//   out_y      : row of the centre pixel
//   frame_done : 1-cycle pulse for the last pixel of a frame
// ---------------------------------------------------------------------------
module sobel_window_gen #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int DW    = 8,
  localparam int XW   = $clog2(IMG_W),
  localparam int YW   = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_pixel,
  output logic          out_valid,
  output logic [DW-1:0] win0,
  output logic [DW-1:0] win1,
  output logic [DW-1:0] win2,
  output logic [DW-1:0] win3,
  output logic [DW-1:0] win4,
  output logic [DW-1:0] win5,
  output logic [DW-1:0] win6,
  output logic [DW-1:0] win7,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic          frame_done
);

  // Raster position of the pixel presented on in_pixel
  logic [XW-1:0] col_r;
  logic [YW-1:0] row_r;

  // Line memories: line_a holds row r-2, line_b holds row r-1 at the current column
  logic [DW-1:0] line_a [IMG_W];
  logic [DW-1:0] line_b [IMG_W];

  // Column history of the window. Column 2 is the most recent column,
  // column 1 the one before it; the incoming pixel forms the new right column.
  logic [DW-1:0] top1_r, top2_r;
  logic [DW-1:0] mid1_r, mid2_r;
  logic [DW-1:0] bot1_r, bot2_r;

  logic [DW-1:0] la_rd_s;
  logic [DW-1:0] lb_rd_s;
  logic          col_last_s;
  logic          row_last_s;
  logic          win_ok_s;
  logic [XW-1:0] col_nxt_s;
  logic [YW-1:0] row_nxt_s;

  // Line reads, window gating and next raster position
  always_comb begin
    la_rd_s    = line_a[col_r];
    lb_rd_s    = line_b[col_r];
    col_last_s = (col_r == XW'(IMG_W - 1));
    row_last_s = (row_r == YW'(IMG_H - 1));
    // Stale line/column data is only ever present when r<2 or c<2, so this
    // single gate covers line wrap, frame start and restart after reset.
    win_ok_s   = (row_r >= YW'(2)) && (col_r >= XW'(2));
    if (col_last_s) begin
      col_nxt_s = {XW{1'b0}};
      if (row_last_s) begin
        row_nxt_s = {YW{1'b0}};
      end else begin
        row_nxt_s = row_r + YW'(1);
      end
    end else begin
      col_nxt_s = col_r + XW'(1);
      row_nxt_s = row_r;
    end
  end

  // Line memory update; contents are deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (in_valid) begin
      line_a[col_r] <= lb_rd_s;
      line_b[col_r] <= in_pixel;
    end
  end

  // Counters, column history and registered window outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      col_r      <= {XW{1'b0}};
      row_r      <= {YW{1'b0}};
      top1_r     <= {DW{1'b0}};
      top2_r     <= {DW{1'b0}};
      mid1_r     <= {DW{1'b0}};
      mid2_r     <= {DW{1'b0}};
      bot1_r     <= {DW{1'b0}};
      bot2_r     <= {DW{1'b0}};
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      win0       <= {DW{1'b0}};
      win1       <= {DW{1'b0}};
      win2       <= {DW{1'b0}};
      win3       <= {DW{1'b0}};
      win4       <= {DW{1'b0}};
      win5       <= {DW{1'b0}};
      win6       <= {DW{1'b0}};
      win7       <= {DW{1'b0}};
      out_x      <= {XW{1'b0}};
      out_y      <= {YW{1'b0}};
    end else begin
      out_valid  <= in_valid && win_ok_s;
      frame_done <= in_valid && col_last_s && row_last_s;
      if (in_valid) begin
        col_r  <= col_nxt_s;
        row_r  <= row_nxt_s;
        top1_r <= top2_r;
        top2_r <= la_rd_s;
        mid1_r <= mid2_r;
        mid2_r <= lb_rd_s;
        bot1_r <= bot2_r;
        bot2_r <= in_pixel;
        if (win_ok_s) begin
          // Window taken from the history before this shift plus the new
          // right column; mid2_r is the centre and is not exported.
          win0  <= top1_r;
          win1  <= top2_r;
          win2  <= la_rd_s;
          win3  <= mid1_r;
          win4  <= lb_rd_s;
          win5  <= bot1_r;
          win6  <= bot2_r;
          win7  <= in_pixel;
          out_x <= col_r - XW'(1);
          out_y <= row_r - YW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_gen.sv
// ---------------------------------------------------------------------------
// tb_sobel_window_gen
//   Directed bench for sobel_window_gen at IMG_W=5, IMG_H=4, DW=8 with pixel
//   value r*16+c (+ base). Each accepted pixel is followed by a check of the
//   registered outputs one cycle later against a neighbourhood model, plus
//   hand-written constants for the first and last windows.
// ---------------------------------------------------------------------------
module tb_sobel_window_gen;

  localparam int W  = 5;
  localparam int H  = 4;
  localparam int DW = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_pixel;
  logic       out_valid;
  logic [7:0] win0, win1, win2, win3, win4, win5, win6, win7;
  logic [2:0] out_x;
  logic [1:0] out_y;
  logic       frame_done;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  sobel_window_gen #(.IMG_W(W), .IMG_H(H), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_pixel   (in_pixel),
    .out_valid  (out_valid),
    .win0       (win0),
    .win1       (win1),
    .win2       (win2),
    .win3       (win3),
    .win4       (win4),
    .win5       (win5),
    .win6       (win6),
    .win7       (win7),
    .out_x      (out_x),
    .out_y      (out_y),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pix(input logic [7:0] base, input int r, input int c);
    return base + 8'(r * 16 + c);
  endfunction

  function automatic logic [63:0] model_win(input logic [7:0] base, input int y, input int x);
    return {pix(base, y-1, x-1), pix(base, y-1, x), pix(base, y-1, x+1),
            pix(base, y,   x-1),                    pix(base, y,   x+1),
            pix(base, y+1, x-1), pix(base, y+1, x), pix(base, y+1, x+1)};
  endfunction

  function automatic logic [63:0] win_bus();
    return {win0, win1, win2, win3, win4, win5, win6, win7};
  endfunction

  // Present one pixel, then check the outputs it produces one cycle later
  task automatic push(input logic [7:0] base, input int r, input int c);
    logic exp_v;
    in_valid = 1'b1;
    in_pixel = pix(base, r, c);
    @(posedge clk);
    #1;
    exp_v = (r >= 2) && (c >= 2);
    check("out_valid", 64'(out_valid), 64'(exp_v));
    check("frame_done", 64'(frame_done), 64'((r == H-1) && (c == W-1)));
    if (out_valid) pulses++;
    if (exp_v) begin
      check("window", win_bus(), model_win(base, r-1, c-1));
      check("out_x", 64'(out_x), 64'(c-1));
      check("out_y", 64'(out_y), 64'(r-1));
    end
  endtask

  // Idle cycles: nothing may be produced
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      check("gap_out_valid", 64'(out_valid), 64'd0);
      check("gap_frame_done", 64'(frame_done), 64'd0);
    end
  endtask

  task automatic frame(input logic [7:0] base, input bit gapped);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        push(base, r, c);
        if (base == 8'h00 && r == 2 && c == 2) begin
          check("first_win", win_bus(), 64'h00_01_02_10_12_20_21_22);
          check("first_x", 64'(out_x), 64'd1);
          check("first_y", 64'(out_y), 64'd1);
        end
        if (base == 8'h00 && r == 3 && c == 4) begin
          check("last_win", win_bus(), 64'h12_13_14_22_24_32_33_34);
          check("last_done", 64'(frame_done), 64'd1);
        end
        if (base == 8'h80 && r == 2 && c == 2) begin
          check("f2_win0", 64'(win0), 64'h80);
          check("f2_win7", 64'(win7), 64'hA2);
        end
        if (gapped) idle(int'($urandom_range(1, 7)));
      end
    end
  endtask

  // Post-reset quiet period: everything must read zero
  task automatic quiet_after_reset();
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_frame_done", 64'(frame_done), 64'd0);
      check("rst_win", win_bus(), 64'd0);
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_pixel = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_win", win_bus(), 64'd0);
    check("reset_xy", 64'({out_x, out_y}), 64'd0);
    rst = 1'b0;
    quiet_after_reset();

    // Continuous frame: first/last window and pulse count
    pulses = 0;
    frame(8'h00, 1'b0);
    idle(1);
    check("pulses_frame", 64'(pulses), 64'd6);

    // Same frame with random gaps between pixels
    pulses = 0;
    frame(8'h00, 1'b1);
    idle(1);
    check("pulses_gapped", 64'(pulses), 64'd6);

    // Two frames back to back, in_valid never dropped between them
    pulses = 0;
    frame(8'h00, 1'b0);
    frame(8'h80, 1'b0);
    idle(1);
    check("pulses_b2b", 64'(pulses), 64'd12);

    // Reset after pixel 0x13, then restart the frame
    pulses = 0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < W; c++) begin
        if (!(r == 1 && c == 4)) push(8'h00, r, c);
      end
    end
    check("pulses_partial", 64'(pulses), 64'd0);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_done", 64'(frame_done), 64'd0);
    rst = 1'b0;
    quiet_after_reset();
    frame(8'h00, 1'b0);
    idle(1);
    check("pulses_restart", 64'(pulses), 64'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
